// File: rtl/rd_pkg.sv
// Shared definitions for the CFEB readout sequencer: phase constants,
// FSM encoding, register bundles and the majority voters used when TMR=1.
package rd_pkg;

   localparam int unsigned PH_W = 4;

   // Phase codes of interest on the free-running 16-phase STATE counter
   localparam logic [PH_W-1:0] PH_FIFO_RD  = 4'd3;   // trigger FIFO read slot
   localparam logic [PH_W-1:0] PH_PBEND    = 4'd12;  // decoded, PBEND seen at 13
   localparam logic [PH_W-1:0] PH_EN50     = 4'd7;   // ENBL50 visible phase
   localparam logic [PH_W-1:0] PH_DIS50    = 4'd15;  // DISBL50 visible phase
   localparam logic [PH_W-1:0] PH_GAP_EXIT = 4'd2;   // FSM back in IDLE at this phase

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ARM  = 3'd1,
      S_SLOT = 3'd2,
      S_WAIT = 3'd3,
      S_NEXT = 3'd4,
      S_DONE = 3'd5,
      S_GAP  = 3'd6
   } seq_state_e;

   typedef struct packed {
      logic [PH_W-1:0] state;
      logic            pbend;
      logic            en50;
      logic            dis50;
   } phase_regs_t;

   typedef struct packed {
      seq_state_e      st;
      logic [3:0]      slot;     // clocks spent in the current sample slot
      logic [3:0]      smp_adr;
      logic [3:0]      sca_adr;
      logic            scnd;     // trigger spans a second SCA block
      logic            blk;      // 0: first block, 1: second block
      logic            smp_vld;
      logic            done;     // TRGDONE / POPL1AN pulse
      logic            busy;
   } seq_regs_t;

   function automatic phase_regs_t vote_ph(input phase_regs_t a, input phase_regs_t b,
                                           input phase_regs_t c);
      return phase_regs_t'((a & b) | (a & c) | (b & c));
   endfunction

   function automatic seq_regs_t vote_seq(input seq_regs_t a, input seq_regs_t b,
                                          input seq_regs_t c);
      return seq_regs_t'((a & b) | (a & c) | (b & c));
   endfunction

endpackage

// File: rtl/rd_phase_ctr.sv
// Free-running 16-phase pipeline counter with registered phase decodes.
// Ports: i_clk, i_rst (sync, active-high); o_state phase code 0..15,
//        o_pbend pulse at 13, o_enbl50 pulse at 7, o_disbl50 pulse at 15.
module rd_phase_ctr
   import rd_pkg::*;
#(
   parameter int unsigned TMR = 0
) (
   input  logic            i_clk,
   input  logic            i_rst,
   output logic [PH_W-1:0] o_state,
   output logic            o_pbend,
   output logic            o_enbl50,
   output logic            o_disbl50
);

   localparam int unsigned NCOPY = (TMR != 0) ? 3 : 1;

   phase_regs_t r_ph [NCOPY];
   phase_regs_t w_cur;
   phase_regs_t w_nxt;

   // Register copies; all copies load the voted next value
   always_ff @(posedge i_clk) begin
      for (int i = 0; i < int'(NCOPY); i++) begin
         if (i_rst) r_ph[i] <= '0;
         else       r_ph[i] <= w_nxt;
      end
   end

   generate
      if (TMR != 0) begin : g_tmr
         assign w_cur = vote_ph(r_ph[0], r_ph[1], r_ph[2]);
      end else begin : g_single
         assign w_cur = r_ph[0];
      end
   endgenerate

   // Decodes look one phase ahead so the pulses line up with the listed STATE
   always_comb begin
      w_nxt       = '0;
      w_nxt.state = w_cur.state + 4'd1;
      w_nxt.pbend = (w_cur.state == PH_PBEND);
      w_nxt.en50  = (w_cur.state == PH_EN50 - 4'd1);
      w_nxt.dis50 = (w_cur.state == PH_DIS50 - 4'd1);
   end

   assign o_state   = w_cur.state;
   assign o_pbend   = w_cur.pbend;
   assign o_enbl50  = w_cur.en50;
   assign o_disbl50 = w_cur.dis50;

endmodule

// File: rtl/rd_seq.sv
// Pipeline phase generator and SCA readout sequencer for the CFEB readout path.
// Ports: i_clk, i_rst (sync, active-high), i_run, i_tempty, i_scnd_blk, i_blkout[3:0],
//        i_out_rdy; o_state[3:0], o_pbend, o_enbl50, o_disbl50, o_trgdone, o_popl1an,
//        o_sca_adr[3:0], o_smp_adr[3:0], o_smp_vld, o_busy.
module rd_seq
   import rd_pkg::*;
#(
   parameter int unsigned TMR     = 0,
   parameter int unsigned NSAMP   = 8,
   parameter int unsigned SMP_CYC = 4
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_run,
   input  logic            i_tempty,
   input  logic            i_scnd_blk,
   input  logic [3:0]      i_blkout,
   input  logic            i_out_rdy,
   output logic [PH_W-1:0] o_state,
   output logic            o_pbend,
   output logic            o_enbl50,
   output logic            o_disbl50,
   output logic            o_trgdone,
   output logic            o_popl1an,
   output logic [3:0]      o_sca_adr,
   output logic [3:0]      o_smp_adr,
   output logic            o_smp_vld,
   output logic            o_busy
);

   localparam int unsigned NCOPY = (TMR != 0) ? 3 : 1;

   logic [PH_W-1:0] w_state;
   seq_regs_t       r_seq [NCOPY];
   seq_regs_t       w_cur;
   seq_regs_t       w_nxt;

   rd_phase_ctr #(.TMR(TMR)) u_phase (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .o_state   (w_state),
      .o_pbend   (o_pbend),
      .o_enbl50  (o_enbl50),
      .o_disbl50 (o_disbl50)
   );

   // FSM and counter registers
   always_ff @(posedge i_clk) begin
      for (int i = 0; i < int'(NCOPY); i++) begin
         if (i_rst) r_seq[i] <= '0;
         else       r_seq[i] <= w_nxt;
      end
   end

   generate
      if (TMR != 0) begin : g_tmr
         assign w_cur = vote_seq(r_seq[0], r_seq[1], r_seq[2]);
      end else begin : g_single
         assign w_cur = r_seq[0];
      end
   endgenerate

   // Next-state logic. NEXT counts as the first clock of the following slot so
   // each sample takes SMP_CYC+1 clocks when OUT_RDY is high.
   always_comb begin
      w_nxt      = w_cur;
      w_nxt.done = 1'b0;
      unique case (w_cur.st)
         S_IDLE: begin
            if (i_run && !i_tempty && (w_state == PH_FIFO_RD)) begin
               w_nxt.st      = S_ARM;
               w_nxt.sca_adr = i_blkout;
               w_nxt.scnd    = i_scnd_blk;
               w_nxt.smp_adr = '0;
               w_nxt.blk     = 1'b0;
               w_nxt.slot    = '0;
            end
         end
         S_ARM: w_nxt.st = S_SLOT;
         S_SLOT: begin
            if (w_cur.slot == 4'(SMP_CYC - 1)) begin
               w_nxt.smp_vld = 1'b1;
               w_nxt.st      = S_WAIT;
            end else begin
               w_nxt.slot = w_cur.slot + 4'd1;
            end
         end
         S_WAIT: begin
            if (i_out_rdy) begin
               w_nxt.smp_vld = 1'b0;
               w_nxt.st      = S_NEXT;
            end
         end
         S_NEXT: begin
            w_nxt.slot = 4'd1;
            if (w_cur.smp_adr != 4'(NSAMP - 1)) begin
               w_nxt.smp_adr = w_cur.smp_adr + 4'd1;
               w_nxt.st      = S_SLOT;
            end else if (w_cur.scnd && !w_cur.blk) begin
               w_nxt.blk     = 1'b1;
               w_nxt.sca_adr = w_cur.sca_adr + 4'd1;
               w_nxt.smp_adr = '0;
               w_nxt.st      = S_SLOT;
            end else begin
               w_nxt.done = 1'b1;
               w_nxt.st   = S_DONE;
            end
         end
         S_DONE: w_nxt.st = S_GAP;
         // Leave one phase early so IDLE is reached exactly at PH_GAP_EXIT
         S_GAP: begin
            if (w_state == PH_GAP_EXIT - 4'd1) w_nxt.st = S_IDLE;
         end
         default: w_nxt.st = S_IDLE;
      endcase
      w_nxt.busy = (w_nxt.st != S_IDLE);
   end

   assign o_state   = w_state;
   assign o_trgdone = w_cur.done;
   assign o_popl1an = w_cur.done;
   assign o_sca_adr = w_cur.sca_adr;
   assign o_smp_adr = w_cur.smp_adr;
   assign o_smp_vld = w_cur.smp_vld;
   assign o_busy    = w_cur.busy;

endmodule

// File: tb/tb_rd_seq.sv
// Directed bench for rd_seq: phase decodes, single/dual block readout,
// OUT_RDY stall, reset abort and back-to-back triggers.
module tb_rd_seq;

   localparam int unsigned NSAMP   = 8;
   localparam int unsigned SMP_CYC = 4;

   logic       clk;
   logic       rst;
   logic       i_run;
   logic       i_tempty;
   logic       i_scnd_blk;
   logic [3:0] i_blkout;
   logic       i_out_rdy;
   logic [3:0] o_state;
   logic       o_pbend;
   logic       o_enbl50;
   logic       o_disbl50;
   logic       o_trgdone;
   logic       o_popl1an;
   logic [3:0] o_sca_adr;
   logic [3:0] o_smp_adr;
   logic       o_smp_vld;
   logic       o_busy;

   int n_tot  = 0;
   int n_bad  = 0;
   int n_xfer = 0;
   int n_done = 0;

   rd_seq #(.TMR(0), .NSAMP(NSAMP), .SMP_CYC(SMP_CYC)) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_run      (i_run),
      .i_tempty   (i_tempty),
      .i_scnd_blk (i_scnd_blk),
      .i_blkout   (i_blkout),
      .i_out_rdy  (i_out_rdy),
      .o_state    (o_state),
      .o_pbend    (o_pbend),
      .o_enbl50   (o_enbl50),
      .o_disbl50  (o_disbl50),
      .o_trgdone  (o_trgdone),
      .o_popl1an  (o_popl1an),
      .o_sca_adr  (o_sca_adr),
      .o_smp_adr  (o_smp_adr),
      .o_smp_vld  (o_smp_vld),
      .o_busy     (o_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count handshakes and TRGDONE pulses as they happen at the clock edge
   always @(posedge clk) begin
      if (!rst) begin
         if (o_smp_vld && i_out_rdy) n_xfer <= n_xfer + 1;
         if (o_trgdone)              n_done <= n_done + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One trigger readout. stall_smp / abort_smp are flat sample indices (-1 = none).
   task automatic read_trig(input logic [3:0] blk, input bit scnd, input int stall_smp,
                            input int stall_len, input int abort_smp,
                            input bit keep_pending, input bit drop_run);
      int         cnt;
      int         x0;
      int         d0;
      int         held;
      int         idx;
      int         nblk;
      bit         seen;
      logic [3:0] exp_sca;
      i_blkout   = blk;
      i_scnd_blk = scnd;
      x0 = n_xfer;
      d0 = n_done;
      cnt = 0;
      while (!o_busy && cnt < 64) begin tick(); cnt++; end
      chk("busy_rise", 32'(o_busy), 32'd1);
      chk("arm_phase", 32'(o_state), 32'd4);
      // Inputs changed after ARM must be ignored
      if (!keep_pending) i_tempty = 1'b1;
      i_scnd_blk = !scnd;
      i_blkout   = blk + 4'd7;
      if (drop_run) i_run = 1'b0;
      nblk = scnd ? 2 : 1;
      for (int b = 0; b < nblk; b++) begin
         for (int s = 0; s < int'(NSAMP); s++) begin
            idx = b * int'(NSAMP) + s;
            tick();
            cnt = 1;
            if (idx == stall_smp) i_out_rdy = 1'b0;
            while (!o_smp_vld && cnt < 100) begin tick(); cnt++; end
            exp_sca = blk + 4'(b);
            chk("smp_gap", 32'(cnt), 32'd5);
            chk("sca_adr", 32'(o_sca_adr), 32'(exp_sca));
            chk("smp_adr", 32'(o_smp_adr), 32'(s));
            if (idx == abort_smp) begin
               rst   = 1'b1;
               i_run = 1'b0;
               tick();
               chk("abort_state", 32'({o_busy, o_smp_vld, o_state, o_trgdone, o_popl1an}), 32'd0);
               rst  = 1'b0;
               seen = 1'b0;
               repeat (40) begin tick(); if (o_busy || o_trgdone) seen = 1'b1; end
               chk("abort_quiet", 32'(seen), 32'd0);
               chk("abort_no_done", 32'(n_done - d0), 32'd0);
               return;
            end
            if (idx == stall_smp) begin
               held = 1;
               repeat (stall_len - 1) begin
                  tick();
                  if (o_smp_vld && o_smp_adr == 4'(s) && o_sca_adr == exp_sca) held++;
               end
               chk("stall_hold", 32'(held), 32'(stall_len));
               i_out_rdy = 1'b1;
            end
         end
      end
      cnt = 0;
      while (!o_trgdone && cnt < 10) begin tick(); cnt++; end
      chk("done_lat", 32'(cnt), 32'd2);
      chk("popl1an", 32'(o_popl1an), 32'd1);
      tick();
      chk("done_pulse", 32'({o_trgdone, o_popl1an}), 32'd0);
      cnt = 0;
      while (o_busy && cnt < 64) begin tick(); cnt++; end
      chk("idle_phase", 32'(o_state), 32'd2);
      chk("xfers", 32'(n_xfer - x0), 32'(nblk * int'(NSAMP)));
      chk("trgdones", 32'(n_done - d0), 32'd1);
   endtask

   initial begin
      logic [3:0] exp_st;
      bit         seen;
      rst        = 1'b1;
      i_run      = 1'b0;
      i_tempty   = 1'b1;
      i_scnd_blk = 1'b0;
      i_blkout   = 4'd0;
      i_out_rdy  = 1'b1;

      // Reset and free-running phase decodes
      repeat (3) tick();
      chk("reset", 32'({o_state, o_pbend, o_enbl50, o_disbl50, o_trgdone, o_popl1an,
                        o_sca_adr, o_smp_adr, o_smp_vld, o_busy}), 32'd0);
      rst = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         tick();
         exp_st = 4'(k);
         chk("phase", 32'({o_state, o_pbend, o_enbl50, o_disbl50, o_busy, o_smp_vld, o_trgdone}),
             32'({exp_st, exp_st == 4'd13, exp_st == 4'd7, exp_st == 4'd15, 3'b000}));
      end

      // Single block from SCA block 5
      i_run    = 1'b1;
      i_tempty = 1'b0;
      read_trig(4'd5, 1'b0, -1, 0, -1, 1'b0, 1'b0);

      // Two blocks wrapping 15 -> 0, RUN dropped mid-readout, FIFO left non-empty
      i_tempty = 1'b0;
      read_trig(4'd15, 1'b1, -1, 0, -1, 1'b1, 1'b1);
      seen = 1'b0;
      repeat (32) begin tick(); if (o_busy) seen = 1'b1; end
      chk("no_arm_run0", 32'(seen), 32'd0);

      // OUT_RDY low for 20 clocks at sample 3
      i_run    = 1'b1;
      i_tempty = 1'b0;
      read_trig(4'd9, 1'b0, 3, 20, -1, 1'b0, 1'b0);

      // Reset during sample 4
      i_run    = 1'b1;
      i_tempty = 1'b0;
      read_trig(4'd2, 1'b0, -1, 0, 4, 1'b0, 1'b0);

      // Three back-to-back triggers
      i_run    = 1'b1;
      i_tempty = 1'b0;
      read_trig(4'd3, 1'b0, -1, 0, -1, 1'b1, 1'b0);
      read_trig(4'd4, 1'b1, -1, 0, -1, 1'b1, 1'b0);
      read_trig(4'd12, 1'b0, -1, 0, -1, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1);
   end

endmodule
